aes_inv_mixcolumns: RTL and testbench
=====================================

Name: aes_inv_mixcolumns

Overview:
- Inverse of the AES MixColumns transform (FIPS-197 InvMixColumns), used on the decryption datapath.
- Byte-serial datapath: one GF(2^8) constant-multiply-accumulate per clock, 64 MACs per 128-bit state.
- Shares the column/byte packing and start/done handshake of the forward MixColumns block, so the round controller drives both identically.
- Result is held in output registers until the next accepted start.

Parameters:
- None. Coefficient matrix, state size and cycle count are fixed by FIPS-197.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start_in  input  1  level request; its rising edge starts one operation.
- state0  input  32  column 0; row r at bits [8r+7:8r].
- state1  input  32  column 1, same packing.
- state2  input  32  column 2, same packing.
- state3  input  32  column 3, same packing.
- state_out0  output  32  result column 0, same packing.
- state_out1  output  32  result column 1, same packing.
- state_out2  output  32  result column 2, same packing.
- state_out3  output  32  result column 3, same packing.
- done  output  1  high while state_out* holds a completed result.

Behaviour:
- Math: out[c][r] = XOR over k=0..3 of gmul(M[r][k], in[c][k]).
- M rows: {0e,0b,0d,09}, {09,0e,0b,0d}, {0d,09,0e,0b}, {0b,0d,09,0e}.
- gmul is combinational. xtime(a) = (a<<1) XOR (a[7] ? 8'h1b : 0), truncated to 8 bits.
- 09 = x8^x1; 0b = x8^x2^x1; 0d = x8^x4^x1; 0e = x8^x4^x2.
- Start detect: start_q registers start_in. start = start_in & ~start_q. start_q resets to 1, so start_in held high through reset release does not trigger.
- FSM states: IDLE, CALC, FINISH, DONE.
- IDLE or DONE, start=1:
  - Capture state0..3 into a 16-byte input register.
  - Clear the 16-byte accumulator and the 6-bit counter cnt.
  - Clear done; go to CALC.
- CALC, each edge:
  - Decode cnt: col = cnt[5:4], row = cnt[3:2], k = cnt[1:0].
  - acc[4*col+row] ^= gmul(M[row][k], in[4*col+k]); then cnt++.
  - At cnt==63 (after that MAC) go to FINISH.
- FINISH: copy acc to the state_out* registers, set done=1, go to DONE.
- DONE: hold outputs and done until the next start or reset.
- Latency: capture edge E0; MACs on E1..E64; done and outputs update on E65. Next start may be accepted on the edge after done rises.
- start rising edge during CALC or FINISH: ignored. No re-capture, no restart, no effect on the current result.
- state0..3 change after the capture edge: no effect on the result.
- state_out* keep the previous result during a new CALC. They change only on the FINISH edge. done is low during CALC.
- reset (any state, including mid-CALC):
  - FSM to IDLE; cnt, acc, input register, state_out* all cleared to 0.
  - done = 0; start_q = 1.
- Reset value of every output is 0.

Test Plan:
- Single column: state0=32'hbca14d8e, others 0, start pulse -> done high on capture edge +65; state_out0=32'h455313db, state_out1..3=0.
- Full state: state0=32'h9d58dc9f, state1=32'h01010101, state2=32'hd6d7d5d5, state3=32'hf8bd7e4d -> state_out0=32'h5c220af2, state_out1=32'h01010101, state_out2=32'hd5d4d4d4, state_out3=32'h4c31262d.
- Start while busy: second start_in rising edge at E30 with different inputs -> ignored; result matches the first capture; done still rises at E65.
- Back-to-back: after done, new start with state0=32'hc6c6c6c6 (others 0) -> done falls on the capture edge; old outputs held through CALC; then state_out0=32'hc6c6c6c6.
- Reset mid-operation: reset high at E20 -> all outputs 0, done 0. Release with start_in held high -> no operation starts until start_in falls and rises again.
- Random regression: 1000 random states vs a software InvMixColumns model. Also check round-trip InvMix(Mix(x)) = x using the forward block's reference model.

Source files
------------

// File: rtl/aes_inv_mixcolumns_if.sv
// Start/done handshake and column-packed state bus shared by the forward and inverse MixColumns blocks.
// Column c, row r sits at state<c>[8r+7:8r]; the round controller is the master side.
interface aes_inv_mixcolumns_if;
  logic        start_in;
  logic [31:0] state0;
  logic [31:0] state1;
  logic [31:0] state2;
  logic [31:0] state3;
  logic [31:0] state_out0;
  logic [31:0] state_out1;
  logic [31:0] state_out2;
  logic [31:0] state_out3;
  logic        done;

  modport master (
    output start_in,
    output state0,
    output state1,
    output state2,
    output state3,
    input  state_out0,
    input  state_out1,
    input  state_out2,
    input  state_out3,
    input  done
  );

  modport slave (
    input  start_in,
    input  state0,
    input  state1,
    input  state2,
    input  state3,
    output state_out0,
    output state_out1,
    output state_out2,
    output state_out3,
    output done
  );
endinterface

// File: rtl/aes_inv_mixcolumns.sv
// Byte-serial AES InvMixColumns: one GF(2^8) MAC per clock, outputs and done update 65 edges after capture.
// No backpressure: starts arriving while busy are dropped; the result is held until the next accepted start.
module aes_inv_mixcolumns (
  input  logic                 clk,
  input  logic                 reset,
  aes_inv_mixcolumns_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic              start_q;
  logic              start;
  logic [15:0][7:0]  in_q;
  logic [15:0][7:0]  acc_q;
  logic [15:0][7:0]  out_q;
  logic [5:0]        cnt_q;
  logic              done_q;

  logic              capture;
  logic              mac_en;
  logic              load_out;

  logic [1:0]        mac_col;
  logic [1:0]        mac_row;
  logic [1:0]        mac_k;
  logic [1:0]        coef_idx;
  logic [3:0]        coef;
  logic [7:0]        mac_in;
  logic [7:0]        mac_prod;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // All InvMixColumns coefficients fit in 4 bits, so one weighted sum of a, 2a, 4a, 8a covers them.
  function automatic logic [7:0] gmul(input logic [3:0] c, input logic [7:0] a);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2   = xtime(a);
    x4   = xtime(x2);
    x8   = xtime(x4);
    gmul = ({8{c[0]}} & a) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
  endfunction

  // Rising-edge detect; start_q resets high so a level held across reset release is not a request.
  assign start = bus.start_in & ~start_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q <= 1'b1;
    end else begin
      start_q <= bus.start_in;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == 6'd63) state_d = FINISH;
      FINISH:  state_d = DONE;
      DONE:    if (start) state_d = CALC;
      default: state_d = IDLE;
    endcase
  end

  // FSM: datapath controls
  always_comb begin
    capture  = 1'b0;
    mac_en   = 1'b0;
    load_out = 1'b0;
    case (state_q)
      IDLE:    capture  = start;
      CALC:    mac_en   = 1'b1;
      FINISH:  load_out = 1'b1;
      DONE:    capture  = start;
      default: capture  = 1'b0;
    endcase
  end

  // Counter walks column-major, then row, then the k term being accumulated.
  assign mac_col  = cnt_q[5:4];
  assign mac_row  = cnt_q[3:2];
  assign mac_k    = cnt_q[1:0];
  // The matrix is circulant: M[row][k] depends only on (k - row) mod 4.
  assign coef_idx = mac_k - mac_row;

  always_comb begin
    coef = 4'he;
    case (coef_idx)
      2'd0: coef = 4'he;
      2'd1: coef = 4'hb;
      2'd2: coef = 4'hd;
      2'd3: coef = 4'h9;
      default: coef = 4'he;
    endcase
  end

  assign mac_in   = in_q[{mac_col, mac_k}];
  assign mac_prod = gmul(coef, mac_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q   <= '0;
      acc_q  <= '0;
      out_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      if (capture) begin
        in_q   <= {bus.state3, bus.state2, bus.state1, bus.state0};
        acc_q  <= '0;
        cnt_q  <= '0;
        done_q <= 1'b0;
      end
      if (mac_en) begin
        acc_q[{mac_col, mac_row}] <= acc_q[{mac_col, mac_row}] ^ mac_prod;
        cnt_q <= cnt_q + 6'd1;
      end
      if (load_out) begin
        out_q  <= acc_q;
        done_q <= 1'b1;
      end
    end
  end

  assign bus.state_out0 = out_q[3:0];
  assign bus.state_out1 = out_q[7:4];
  assign bus.state_out2 = out_q[11:8];
  assign bus.state_out3 = out_q[15:12];
  assign bus.done       = done_q;

endmodule

// File: tb/tb_aes_inv_mixcolumns.sv
// Scoreboard bench for aes_inv_mixcolumns: directed FIPS-197 vectors, busy/abort cases, random and round-trip states.
module tb_aes_inv_mixcolumns;

  logic clk;
  logic reset;

  aes_inv_mixcolumns_if bus ();

  aes_inv_mixcolumns dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [127:0] sb_q[$];
  logic [127:0] last_result;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    logic       hi;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa = aa ^ 8'h1b;
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Generic column mix; row r of the matrix is the base row rotated right by r.
  function automatic logic [127:0] mix_model(input logic [127:0] s, input logic [31:0] base_row);
    logic [127:0] o;
    logic [7:0]   m [4];
    logic [7:0]   b;
    m[0] = base_row[31:24];
    m[1] = base_row[23:16];
    m[2] = base_row[15:8];
    m[3] = base_row[7:0];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) begin
          b = b ^ gf_mul(m[(k - r + 4) % 4], s[8*(4*c+k) +: 8]);
        end
        o[8*(4*c+r) +: 8] = b;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    return mix_model(s, 32'h0e0b0d09);
  endfunction

  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    return mix_model(s, 32'h02030101);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive_state(input logic [127:0] s);
    bus.state0 = s[31:0];
    bus.state1 = s[63:32];
    bus.state2 = s[95:64];
    bus.state3 = s[127:96];
  endtask

  function automatic logic [127:0] outs();
    return {bus.state_out3, bus.state_out2, bus.state_out1, bus.state_out0};
  endfunction

  // One operation: pulse start, disturb inputs after capture, optionally re-start while busy,
  // check held outputs mid-CALC, then compare against the scoreboard when done rises.
  task automatic run_op(input logic [127:0] st, input logic [127:0] exp, input string tag,
                        input int busy_at);
    int  n;
    bit  got;
    @(negedge clk);
    drive_state(st);
    bus.start_in = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    chk({tag, "_done_clr"}, {127'd0, bus.done}, 128'd0);
    n   = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      n++;
      @(negedge clk);
      if (n == 1) bus.start_in = 1'b0;
      if (n == 5) drive_state(rand128());
      if (busy_at > 0 && n == busy_at) begin
        drive_state(rand128());
        bus.start_in = 1'b1;
      end
      if (busy_at > 0 && n == busy_at + 3) bus.start_in = 1'b0;
      @(posedge clk);
      #1;
      if (n == 32) begin
        chk({tag, "_hold"}, outs(), last_result);
        chk({tag, "_busy_done"}, {127'd0, bus.done}, 128'd0);
      end
      if (bus.done) begin
        got = 1'b1;
        chk({tag, "_latency"}, 128'(n), 128'd65);
        if (sb_q.size() == 0) begin
          chk({tag, "_sb_underflow"}, 128'd0, 128'd1);
        end else begin
          chk(tag, outs(), sb_q.pop_front());
        end
        last_result = outs();
      end
    end
    if (!got) begin
      chk({tag, "_timeout"}, 128'd0, 128'd1);
      sb_q.delete();
    end
    bus.start_in = 1'b0;
  endtask

  initial begin
    logic [127:0] x;
    bit           spurious;

    reset        = 1'b1;
    bus.start_in = 1'b0;
    drive_state('0);
    last_result  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 128'd0);
    chk("reset_done", {127'd0, bus.done}, 128'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op({32'h0, 32'h0, 32'h0, 32'hbca14d8e},
           {32'h0, 32'h0, 32'h0, 32'h455313db}, "single_col", 0);
    run_op({32'hf8bd7e4d, 32'hd6d7d5d5, 32'h01010101, 32'h9d58dc9f},
           {32'h4c31262d, 32'hd5d4d4d4, 32'h01010101, 32'h5c220af2}, "full_state", 0);
    run_op({32'h0, 32'h0, 32'h0, 32'hbca14d8e},
           {32'h0, 32'h0, 32'h0, 32'h455313db}, "start_busy", 30);
    run_op({32'h0, 32'h0, 32'h0, 32'hc6c6c6c6},
           {32'h0, 32'h0, 32'h0, 32'hc6c6c6c6}, "back_to_back", 0);

    // Abort mid-CALC with start_in held high across reset release.
    @(negedge clk);
    drive_state({32'hf8bd7e4d, 32'hd6d7d5d5, 32'h01010101, 32'h9d58dc9f});
    bus.start_in = 1'b1;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_outs", outs(), 128'd0);
    chk("abort_done", {127'd0, bus.done}, 128'd0);
    @(negedge clk);
    reset       = 1'b0;
    last_result = '0;
    spurious    = 1'b0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (bus.done || outs() != '0) spurious = 1'b1;
    end
    chk("held_start_ignored", {127'd0, spurious}, 128'd0);
    @(negedge clk);
    bus.start_in = 1'b0;
    run_op({32'h0, 32'h0, 32'h0, 32'hc6c6c6c6},
           {32'h0, 32'h0, 32'h0, 32'hc6c6c6c6}, "after_abort", 0);

    for (int i = 0; i < 1000; i++) begin
      x = rand128();
      if (i % 2 == 0) run_op(x, inv_mix(x), "rand", 0);
      else            run_op(fwd_mix(x), x, "round_trip", 0);
    end

    chk("sb_empty", 128'(sb_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
